// File: rtl/moore_state_reg_ej1.sv
// rtl/moore_state_reg_ej1.sv - Moore state register with input synchronizers, change strobe and dwell counter
// The next-state logic lives outside; this block registers it, strobes on change and times dwell.
module moore_state_reg_ej1 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inputI,
  input  logic       inputS,
  input  logic       enable,
  input  logic       nextY1,
  input  logic       nextY2,
  output logic       syncI,
  output logic       syncS,
  output logic       stateY1,
  output logic       stateY2,
  output logic       outZ,
  output logic       stateChange,
  output logic [7:0] dwellCount
);

  typedef enum logic [1:0] {ST00 = 2'b00, ST01 = 2'b01, ST10 = 2'b10, ST11 = 2'b11} state_t;

  state_t     state_q, state_d;
  logic       i_meta, s_meta, i_sync, s_sync;
  logic       change_d, change_q;
  logic [7:0] dwell_d, dwell_q;

  // Synchronizers reset high so the first post-reset next state is ST00.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_meta <= 1'b1;
      i_sync <= 1'b1;
      s_meta <= 1'b1;
      s_sync <= 1'b1;
    end else begin
      i_meta <= inputI;
      i_sync <= i_meta;
      s_meta <= inputS;
      s_sync <= s_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST00;
      change_q <= 1'b0;
      dwell_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      change_q <= change_d;
      dwell_q  <= dwell_d;
    end
  end

  // A load of the same state is not a change: no strobe, no counter clear.
  always_comb begin
    state_d  = state_q;
    change_d = 1'b0;
    if (enable) begin
      state_d  = state_t'({nextY1, nextY2});
      change_d = (state_d != state_q);
    end
    if (change_d)
      dwell_d = 8'd0;
    else if (dwell_q == 8'hFF)
      dwell_d = dwell_q;
    else
      dwell_d = dwell_q + 8'd1;
  end

  always_comb begin
    outZ        = (state_q == ST11);
    stateY1     = state_q[1];
    stateY2     = state_q[0];
    stateChange = change_q;
    dwellCount  = dwell_q;
    syncI       = i_sync;
    syncS       = s_sync;
  end

endmodule

// File: tb/tb_moore_state_reg_ej1.sv
// tb/tb_moore_state_reg_ej1.sv - directed scenarios with a reference model feeding an expected-value queue
module tb_moore_state_reg_ej1;

  logic       clk = 1'b0;
  logic       reset, inputI, inputS, enable, nextY1, nextY2;
  logic       syncI, syncS, stateY1, stateY2, outZ, stateChange;
  logic [7:0] dwellCount;
  logic [1:0] nxt;

  int n_vec = 0;
  int n_err = 0;

  logic [13:0] exp_q[$];

  // reference model state
  logic       m_i1 = 1'b1, m_i2 = 1'b1, m_s1 = 1'b1, m_s2 = 1'b1;
  logic [1:0] m_st = 2'b00;
  logic       m_chg = 1'b0;
  int         m_dw = 0;

  always #5 clk = ~clk;

  moore_state_reg_ej1 dut (
    .clk(clk), .reset(reset), .inputI(inputI), .inputS(inputS), .enable(enable),
    .nextY1(nextY1), .nextY2(nextY2), .syncI(syncI), .syncS(syncS),
    .stateY1(stateY1), .stateY2(stateY2), .outZ(outZ), .stateChange(stateChange),
    .dwellCount(dwellCount)
  );

  function automatic logic [1:0] next_of(input logic si, input logic ss, input logic [1:0] st);
    if (!si)      return 2'b11;
    else if (ss)  return 2'b00;
    else if (st == 2'b10) return 2'b01;
    else          return 2'b10;
  endfunction

  // combinational next-state stage attached to the DUT
  always_comb begin
    nxt    = next_of(syncI, syncS, {stateY1, stateY2});
    nextY1 = nxt[1];
    nextY2 = nxt[0];
  end

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic i, input logic s, input logic e, input string tag);
    logic [1:0]  nx;
    logic [13:0] obs;
    reset = r; inputI = i; inputS = s; enable = e;
    nx = next_of(m_i2, m_s2, m_st);
    if (r) begin
      m_i1 = 1; m_i2 = 1; m_s1 = 1; m_s2 = 1; m_st = 2'b00; m_chg = 0; m_dw = 0;
    end else begin
      m_i2 = m_i1; m_i1 = i; m_s2 = m_s1; m_s1 = s;
      if (e && nx != m_st) begin
        m_st = nx; m_chg = 1; m_dw = 0;
      end else begin
        m_chg = 0;
        if (m_dw < 255) m_dw++;
      end
    end
    exp_q.push_back({m_i2, m_s2, m_st, (m_st == 2'b11), m_chg, 8'(m_dw)});
    @(posedge clk);
    #1;
    obs = {syncI, syncS, stateY1, stateY2, outZ, stateChange, dwellCount};
    check(tag, obs, exp_q.pop_front());
  endtask

  initial begin
    int cnt_st11, cnt_il, strobes;
    logic [1:0] frozen;

    step(1, 1, 1, 1, "reset0");
    step(1, 1, 1, 1, "reset1");

    // 1: steady I=S=1
    repeat (10) step(0, 1, 1, 1, "s1");
    check("s1_dwell10", {6'd0, dwellCount}, 14'd10);
    check("s1_st00", {11'd0, stateY1, stateY2, outZ}, 14'd0);

    // 2: drop I, ST11 after the third edge
    repeat (3) step(0, 0, 1, 1, "s2");
    check("s2_enter11", {10'd0, stateY1, stateY2, outZ, stateChange}, 14'b1111);
    step(0, 0, 1, 1, "s2");
    check("s2_after", {stateY1, stateY2, outZ, stateChange, 2'b00, dwellCount}, {4'b1110, 2'b00, 8'd1});

    // 5: reset while in ST11 with dwell 40
    for (int k = 0; k < 100 && m_dw != 40; k++) step(0, 0, 1, 1, "s5_wait");
    check("s5_dwell40", {6'd0, dwellCount}, 14'd40);
    step(1, 0, 1, 1, "s5_reset");
    check("s5_regs", {8'd0, stateY1, stateY2, outZ, stateChange, syncI, syncS},
          {8'd0, 6'b000011});
    check("s5_dwell0", {6'd0, dwellCount}, 14'd0);
    step(0, 1, 1, 1, "s5_post");
    check("s5_nostrobe", {13'd0, stateChange}, 14'd0);
    repeat (3) step(0, 1, 1, 1, "s5_post");

    // 3: I=1, S=0 alternates ST10/ST01
    strobes = 0;
    for (int k = 0; k < 12; k++) begin
      step(0, 1, 0, 1, "s3");
      if (k >= 2 && stateChange === 1'b1 && dwellCount === 8'd0) strobes++;
    end
    check("s3_strobes", 14'(strobes), 14'd10);

    // 4: enable low, state frozen, dwell saturates
    frozen = {stateY1, stateY2};
    for (int k = 0; k < 560; k++) step(0, k[0], 0, 0, "s4");
    check("s4_sat", {4'd0, stateY1, stateY2, stateChange, 1'b0, dwellCount},
          {4'd0, frozen, 1'b0, 1'b0, 8'd255});

    // 6: one-cycle I glitch visits ST11 for a single cycle
    repeat (5) step(0, 1, 1, 1, "s6_settle");
    step(0, 0, 1, 1, "s6_glitch");
    cnt_st11 = 0; cnt_il = 0;
    for (int k = 0; k < 8; k++) begin
      if ({stateY1, stateY2} === 2'b11) cnt_st11++;
      if (syncI === 1'b0) cnt_il++;
      step(0, 1, 1, 1, "s6");
    end
    check("s6_st11_once", 14'(cnt_st11), 14'd1);
    check("s6_synci_low_once", 14'(cnt_il), 14'd1);
    check("s6_end00", {11'd0, stateY1, stateY2, outZ}, 14'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/moore_state_reg_ej1.md
MOORE_STATE_REG_EJ1 -- requirements
Module: moore_state_reg_ej1

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 inputI  input  1  raw asynchronous I input.
REQ-005 inputS  input  1  raw asynchronous S input.
REQ-006 enable  input  1  state-advance enable.
REQ-007 nextY1, nextY2  input  1 each  next-state bits returned by the downstream combinational next-state stage.
REQ-008 syncI, syncS  output  1 each  synchronized I and S, driven to the combinational stage.
REQ-009 stateY1, stateY2  output  1 each  current state bits (y1, y2), fed back to the combinational stage.
REQ-010 outZ  output  1  Moore output.
REQ-011 stateChange  output  1  one-cycle strobe: the state register changed on the previous edge.
REQ-012 dwellCount  output  8  number of cycles spent in the current state.

Function
REQ-013 inputI and inputS SHALL each pass through a two-flop synchronizer; syncI and syncS are the second-flop outputs, so latency is 2 edges.
REQ-014 The state register {stateY1,stateY2} SHALL load {nextY1,nextY2} on each rising edge where enable=1 and reset=0, and SHALL otherwise hold.
REQ-015 States: ST00, ST01, ST10, ST11, encoded as {y1,y2}.
REQ-016 With the combinational stage attached, the integrated transitions SHALL be:
- syncI=0 -> ST11 from any state.
- syncI=1, syncS=1 -> ST00.
- syncI=1, syncS=0: ST00->ST10, ST01->ST10, ST10->ST01, ST11->ST10.
REQ-017 outZ SHALL be 1 iff the state is ST11; it is decoded from the state register only and has no input path.
REQ-018 stateChange SHALL be registered: it is 1 in the cycle after an edge where the loaded state differed from the held state, and 0 otherwise.
REQ-019 dwellCount SHALL go to 0 on any edge where the state changes.
REQ-020 Otherwise, dwellCount SHALL increment by 1 per edge and saturate at 255 with no wrap.
REQ-021 When enable=0, the state SHALL hold, stateChange SHALL be 0, and dwellCount SHALL keep counting with saturation.
REQ-022 A load where next equals current, such as ST00 with syncS=1, SHALL count as no change: no strobe and no counter clear.
REQ-023 End-to-end latency from a stable raw input to the state update SHALL be 3 rising edges: 2 synchronizer edges plus 1 state edge.

Reset
REQ-024 On a reset edge the following values SHALL apply:
- stateY1=0, stateY2=0 (ST00).
- outZ=0, stateChange=0, dwellCount=0.
- Both synchronizer stages for I and S = 1, so the first post-reset next state is ST00.
REQ-025 Reset SHALL take priority over enable and over nextY1/nextY2.
REQ-026 A reset asserted mid-operation SHALL return all registers to their reset values on that edge, with no residual strobe afterwards.
REQ-027 The block SHALL contain no asynchronous reset paths.

Verification
The bench instantiates this block together with a model of the combinational next-state stage.
REQ-028 Scenario 1: reset; inputI=1, inputS=1, enable=1 for 10 cycles -> state ST00, outZ=0, stateChange never 1, dwellCount=10.
REQ-029 Scenario 2: from ST00, drop inputI to 0 at cycle t -> state=ST11 after the 3rd edge; stateChange=1 for exactly one cycle after that; outZ=1; dwellCount=0 then increments.
REQ-030 Scenario 3: inputI=1, inputS=0, enable=1 starting in ST00 -> sequence ST10, ST01, ST10, ST01, ...; stateChange=1 every cycle; dwellCount stays 0.
REQ-031 Scenario 4: enable=0 while inputI toggles -> state frozen, stateChange=0; dwellCount climbs to 255 and stays at 255 for 300 or more cycles.
REQ-032 Scenario 5: reset pulse while in ST11 with dwellCount=40 -> next cycle state ST00, outZ=0, dwellCount=0, stateChange=0, syncI=1, syncS=1.
REQ-033 Scenario 6: a 1-cycle inputI=0 glitch -> syncI shows a 1-cycle low 2 edges later; the state visits ST11 for exactly one cycle, then resolves per REQ-016.
